// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: owns the per-channel cfg words feeding the PWM bank.
// Target values arrive from the bus (fixed priority) or the DSP stream. They
// reach cfg_o only on each channel's metacycle sync pulse, so a dither
// sequence always runs on one consistent value. A non-zero ramp_step limits
// how far cfg moves toward its target per sync.
module pwm_cfg_sequencer #(
  parameter int NCH = 4,
  parameter int CCW = 24,
  parameter int CHW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_we,
  input  logic [CHW-1:0]       bus_ch,
  input  logic [CCW-1:0]       bus_data,
  output logic                 bus_ack,
  input  logic                 dsp_valid,
  input  logic [CHW-1:0]       dsp_ch,
  input  logic [CCW-1:0]       dsp_data,
  output logic                 dsp_ready,
  input  logic [CCW-1:0]       ramp_step,
  input  logic [NCH-1:0]       pwm_s_i,
  output logic [NCH*CCW-1:0]   cfg_o,
  output logic [NCH-1:0]       busy_o,
  output logic                 err_o
);

  logic [CCW-1:0] target_q [NCH];
  logic [CCW-1:0] target_d [NCH];
  logic [CCW-1:0] cfg_q    [NCH];
  logic [CCW-1:0] cfg_d    [NCH];
  logic [NCH-1:0] busy_q, busy_d;
  logic           bus_ack_q, bus_ack_d;
  logic           err_q, err_d;

  logic           wr_en;
  logic           wr_ok;
  logic [CHW-1:0] wr_ch;
  logic [CCW-1:0] wr_data;

  // One step of the slew limiter. The distance is formed first and compared
  // to the step, so cur+step is only taken when it is known to stay below
  // tgt and can never wrap.
  function automatic logic [CCW-1:0] ramp_next(input logic [CCW-1:0] cur,
                                               input logic [CCW-1:0] tgt,
                                               input logic [CCW-1:0] step);
    logic [CCW-1:0] diff;
    diff      = '0;
    ramp_next = cur;
    if (step == '0) begin
      ramp_next = tgt;
    end else if (tgt > cur) begin
      diff      = tgt - cur;
      ramp_next = (diff > step) ? (cur + step) : tgt;
    end else if (tgt < cur) begin
      diff      = cur - tgt;
      ramp_next = (diff > step) ? (cur - step) : tgt;
    end
  endfunction

  // The bus is never stalled; the DSP stream only proceeds when the bus is idle.
  assign dsp_ready = ~bus_we & ~rst;

  // Arbitrate the single target-write slot and flag out-of-range channels.
  always_comb begin
    wr_en   = bus_we | dsp_valid;
    wr_ch   = bus_we ? bus_ch   : dsp_ch;
    wr_data = bus_we ? bus_data : dsp_data;
    wr_ok   = wr_en && (32'(wr_ch) < NCH);
    err_d   = err_q | (wr_en & ~wr_ok);
    bus_ack_d = bus_we;
  end

  // Next target: the accepted write lands in its channel, others hold.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      target_d[n] = target_q[n];
      if (wr_ok && (wr_ch == CHW'(n))) begin
        target_d[n] = wr_data;
      end
    end
  end

  // Next cfg: moves only on the channel's sync and always works from the
  // pre-write target, so a write racing the sync lands one metacycle later.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      cfg_d[n]  = pwm_s_i[n] ? ramp_next(cfg_q[n], target_q[n], ramp_step)
                             : cfg_q[n];
      busy_d[n] = (target_d[n] != cfg_d[n]);
    end
  end

  // State registers; reset drops every target, cfg and outstanding flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        target_q[n] <= '0;
        cfg_q[n]    <= '0;
      end
      busy_q    <= '0;
      bus_ack_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        target_q[n] <= target_d[n];
        cfg_q[n]    <= cfg_d[n];
      end
      busy_q    <= busy_d;
      bus_ack_q <= bus_ack_d;
      err_q     <= err_d;
    end
  end

  // Flatten the per-channel cfg words onto the output bus.
  always_comb begin
    cfg_o = '0;
    for (int n = 0; n < NCH; n++) begin
      cfg_o[n*CCW +: CCW] = cfg_q[n];
    end
  end

  assign busy_o  = busy_q;
  assign bus_ack = bus_ack_q;
  assign err_o   = err_q;

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
Sits between the register bus / DSP outputs and the bank of PWM channels, and owns each channel's 24-bit cfg word. Arbitrates target writes from two requesters: a bus write port and a DSP valid/ready stream. Applies new values only at each channel's metacycle sync pulse, so every 16-cycle dither sequence runs on one consistent value. An optional slew limit ramps cfg toward the target by a bounded step per metacycle.

Parameters:
NCH, 4, number of PWM channels (1..8)
CCW, 24, cfg width per channel (matches PWM cfg width)
CHW, 3, channel-index width; indices >= NCH are invalid

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
bus_we  input  1  bus write strobe, single-cycle
bus_ch  input  CHW  bus target channel
bus_data  input  CCW  bus target value
bus_ack  output  1  pulses 1 cycle after every accepted bus_we
dsp_valid  input  1  DSP request valid
dsp_ch  input  CHW  DSP target channel
dsp_data  input  CCW  DSP target value
dsp_ready  output  1  DSP request accepted when valid&ready
ramp_step  input  CCW  max |cfg change| per sync; 0 = immediate load
pwm_s_i  input  NCH  per-channel sync pulse from each PWM (one cycle before its metacycle end)
cfg_o  output  NCH*CCW  channel n cfg at bits [n*CCW +: CCW]
busy_o  output  NCH  channel n cfg_o != target
err_o  output  1  sticky: write to channel index >= NCH; cleared only by rst

Behaviour:
- Reset (async, rst=1): targets=0, cfg_o=0, busy_o=0, bus_ack=0, err_o=0. dsp_ready=0 while rst=1.
- Arbitration: at most one target write per cycle. Bus has fixed priority.
- dsp_ready = ~bus_we (combinational, 0 during rst).
- A DSP request stalls while bus_we=1. DSP must hold ch/data until accepted.
- bus_we is always accepted: bus_ack=1 in the following cycle.
- Target write: target[ch] <= data at the accept edge.
- Invalid index (ch >= NCH): no state change, err_o <= 1. The bus write is still acked; the DSP request is still consumed.
- Sync update: on clock edge where pwm_s_i[n]=1:
  - ramp_step==0: cfg[n] <= target[n].
  - else if target>cfg: cfg <= cfg + min(step, target-cfg).
  - else if target<cfg: cfg <= cfg - min(step, cfg-target).
  - Unsigned arithmetic, no overshoot, no wrap. Compute the difference first, then compare to step; never form cfg+step at CCW width.
- Between sync pulses cfg_o[n] is stable. Target writes never alter cfg_o directly.
- Simultaneous target write and pwm_s_i for the same channel: the update uses the pre-write target. The new target applies at the next sync.
- Multiple channels syncing in the same cycle update independently and in parallel.
- busy_o[n] is registered, reflecting target[n]!=cfg[n] after the edge (1-cycle latency from either change).
- ramp_step changes take effect at the next sync. No latching.
- pwm_s_i held high for k cycles produces k ramp steps; sources must pulse.
- Reset mid-ramp: everything returns to 0 immediately. Outstanding DSP transactions are dropped.
- Write latency: accept edge to cfg_o change is the wait for next pwm_s_i[n], plus 1 clk.

Test Plan:
- Reset, then bus_we ch=1 data=0x123456, no sync -> bus_ack one cycle later, cfg_o[1]=0, busy_o[1]=1. Pulse pwm_s_i[1] -> cfg_o[1]=0x123456, busy_o[1]=0 next cycle.
- Simultaneous bus_we ch=0 data=0x10 and dsp_valid ch=2 data=0x20 -> dsp_ready=0 that cycle; DSP accepted next cycle. After syncs on ch0 and ch2: cfg_o[0]=0x10, cfg_o[2]=0x20.
- ramp_step=0x100, cfg_o[3]=0, target 0x250 -> successive pwm_s_i[3] pulses give 0x100, 0x200, 0x250, 0x250. busy_o[3] drops after the third pulse. Repeat downward 0x250->0 (0x150, 0x50, 0).
- Clamp at range limits: ramp_step=0xFFFFFF, target 0xFFFFFF from 0 -> one sync reaches 0xFFFFFF, no wrap. Target 0 from 0xFFFFFF -> one sync reaches 0.
- Write to ch=0 in the same cycle as pwm_s_i[0], old target 0x5, new target 0x9 -> cfg_o[0]=0x5; next sync -> 0x9.
- dsp_valid ch=6 with NCH=4 -> request consumed, err_o=1 sticky, no cfg/target change. Assert rst mid-ramp -> all outputs 0 immediately (async), err_o=0.
